khazad_sbox_layer: RTL and testbench
====================================

# khazad_sbox_layer

Time-multiplexed KHAZAD nonlinear (gamma) layer: applies the 8-bit KHAZAD S-box independently to every byte of a BYTES-byte block using only LANES S-box instances, iterating over BYTES/LANES beats. It sits between the key-addition stage and the linear diffusion stage of the round datapath. It trades area for latency through the LANES parameter and has valid/ready handshakes on both sides so it can be stalled by downstream logic.

## Interface
- BYTES, 8, block width in bytes; the KHAZAD block is 8.
- LANES, 2, S-box instances; must divide BYTES, otherwise an elaboration error.
- BEATS (localparam), BYTES/LANES, processing beats per block.
- clk  input  1  system clock; everything is synchronous to the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream block present on in_data.
- in_ready  output  1  block accepted when in_valid && in_ready.
- in_data  input  8*BYTES  block; byte i = in_data[8i+7:8i].
- out_valid  output  1  result present on out_data.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out_data  output  8*BYTES  result; byte i = S(in byte i).
- busy  output  1  high in RUN or DONE.

## Operation
- Each S-box instance is the standard KHAZAD (tweak) S-box, built from P/Q 4-bit mini-boxes. S is an involution.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On accept: capture in_data into the working register, clear beat counter k, and go to RUN. If BEATS==1, go directly to DONE with the substituted value registered.
- RUN:
  - Each cycle, lane j substitutes byte k*LANES+j in place and k increments.
  - When k==BEATS-1, that cycle's bytes are written and the state goes to DONE.
  - Byte positions in out_data never depend on LANES. The implementation may rotate or index internally.
- DONE:
  - out_valid=1; out_data equals the fully substituted register.
  - On out_ready, go to IDLE. out_data keeps its last value after the handoff.
- in_ready is 0 in RUN and DONE. Inputs offered then are ignored and must be held by upstream.
- out_data and out_valid stay stable while out_valid && !out_ready.
- Counter k is $clog2(BEATS) bits, with a minimum of 1. It never wraps mid-block and is cleared on each accept.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 in the first cycle after rst deasserts. out_valid=0, busy=0, out_data=0, state IDLE, k=0.
- rst asserted in any state, including mid-RUN or in DONE with out_valid high:
  - The block is discarded and no out_valid pulse occurs for it.
  - The next cycle the block is in IDLE with reset values.
- Latency: for an accept at edge T, out_valid is high in the cycle following edge T+BEATS-1, i.e. BEATS cycles after the accept. LANES=1/2/4/8 with BYTES=8 gives 8/4/2/1 cycles.
- Throughput: one block per BEATS+1 cycles when out_ready is held high. There is no accept in the same cycle as the output handoff.
- A single-cycle out_ready pulse in the first DONE cycle completes the handoff. in_ready rises the following cycle.

## Test plan
- Zero block (LANES=2): accept in_data=64'h0 → out_valid exactly 4 cycles after accept, out_data=64'hBABABABABABABABA, and busy high over those 4 cycles.
- Byte ordering (LANES=2): in_data=64'h0706050403020100 → out_data=64'h4DD2D353742F54BA.
- Involution and random vectors: 1000 random blocks, each result fed back as the next input → every second result equals the original input. All results match the software S-box table model.
- Backpressure: out_ready held low 5 cycles after out_valid rises → out_valid and out_data are constant and in_ready=0 throughout. A new in_valid during the stall is not accepted. Releasing out_ready gives a handoff, then in_ready=1 the next cycle.
- Reset mid-RUN: assert rst at beat 2 of a BEATS=4 block → the next cycle has out_valid=0, busy=0, out_data=0, and in_ready=1 after rst drops. The next block (64'h0) yields 64'hBABABABABABABABA with normal latency and no stale bytes.
- Parameter sweep: LANES ∈ {1,2,4,8} with BYTES=8, same vectors → identical out_data. Measured latency is 8/4/2/1 cycles. LANES=3 fails elaboration.

Source files
------------

// File: rtl/khazad_sbox_layer_if.sv
// Valid/ready bundle between the key-addition stage, the KHAZAD gamma layer
// and the linear diffusion stage.
interface khazad_sbox_layer_if #(
  parameter int BYTES = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [8*BYTES-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [8*BYTES-1:0] out_data;
  logic               busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/khazad_sbox_layer.sv
// KHAZAD gamma layer: LANES S-box instances swept over a BYTES-byte block in
// BYTES/LANES beats, with valid/ready handshakes on both sides.

// One KHAZAD S-box (the P/Q mini-box involution) in truth-table form.
module khazad_sbox_lane (
  input  logic [7:0] i_x,
  output logic [7:0] o_y
);
  localparam logic [2047:0] SBOX = {
    128'hBA542F7453D3D24D50AC8DBF70529A4C,
    128'hEAD597D133515BA6DE48A899DB32B7FC,
    128'hE39E919BE2BB416EA5CB6B95A1F3B102,
    128'hCCC41D14C363DA5D5FDC7DCD7F5A6C5C,
    128'hF726FFEDE89D6F8E19A0F0890F07AFFB,
    128'h08150D040164DF7679DD3D163F376D38,
    128'hB973E93555717B8C7288F62A3E5E2746,
    128'h0C65686103C157D6D958D866D73AC83C,
    128'hFA96A798ECB8C7AE694BABA9670A47F2,
    128'hB522E5EEBE2B8112831B0E23F54521CE,
    128'h492CF9E6B62817821A8BFE8A09C9874E,
    128'hE12EE4E0EB90A41E85600025F4F1940B,
    128'hE775EF3431D4D0867EADFD29303B9FF8,
    128'hC6130605C511777C7A78361C39591856,
    128'hB3B02420B292A3C0446210B4844393C2,
    128'h4ABD8F2DBC9C6A40CFA2804F1FCAAA42
  };

  // Entry x sits at bits 2047-8x down; 2047-8x == {~x, 3'b111}.
  assign o_y = SBOX[{~i_x, 3'b111} -: 8];
endmodule

module khazad_sbox_layer #(
  parameter int BYTES = 8,
  parameter int LANES = 2
) (
  input logic                clk,
  input logic                rst,
  khazad_sbox_layer_if.slave bus
);
  localparam int LANES_SAFE = (LANES > 0) ? LANES : 1;
  localparam int BEATS      = BYTES / LANES_SAFE;
  localparam int KW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW         = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [KW-1:0] LAST_K = KW'((BEATS > 1) ? BEATS - 2 : 0);

  if ((LANES < 1) || (BYTES % LANES_SAFE != 0)) begin : g_bad_lanes
    $error("khazad_sbox_layer: LANES (%0d) must divide BYTES (%0d)", LANES, BYTES);
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 r_state;
  logic [KW-1:0]          r_k;
  logic [BYTES-1:0][7:0]  r_work;
  logic [BYTES-1:0][7:0]  r_out;
  logic                   r_out_valid;
  logic                   r_busy;
  logic                   r_rdy;

  logic [BYTES-1:0][7:0]  w_base;
  logic [BYTES-1:0][7:0]  w_next;
  logic [KW-1:0]          w_beat;
  logic [LANES-1:0][IW-1:0] w_idx;
  logic [LANES-1:0][7:0]  w_lane_in;
  logic [LANES-1:0][7:0]  w_lane_out;

  // Beat 0 is substituted straight off in_data on the accept edge, so RUN
  // handles beats 1..BEATS-1 and r_k ends at BEATS-1 when the block lands.
  always_comb begin
    w_base = (r_state == S_IDLE) ? bus.in_data : r_work;
    w_beat = (r_state == S_IDLE) ? '0 : r_k + 1'b1;
    for (int j = 0; j < LANES; j++) begin
      w_idx[j]     = IW'(int'(w_beat) * LANES + j);
      w_lane_in[j] = w_base[w_idx[j]];
    end
  end

  always_comb begin
    w_next = w_base;
    for (int j = 0; j < LANES; j++) begin
      w_next[w_idx[j]] = w_lane_out[j];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    khazad_sbox_lane u_sbox (
      .i_x (w_lane_in[j]),
      .o_y (w_lane_out[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_work      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rdy       <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_rdy) begin
            r_work <= w_next;
            r_k    <= '0;
            r_rdy  <= 1'b0;
            r_busy <= 1'b1;
            if (BEATS == 1) begin
              r_state     <= S_DONE;
              r_out       <= w_next;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_work <= w_next;
          r_k    <= r_k + 1'b1;
          if (r_k == LAST_K) begin
            r_state     <= S_DONE;
            r_out       <= w_next;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rdy       <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gating with rst keeps in_ready low in the reset cycle itself.
  assign bus.in_ready  = r_rdy & ~rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_khazad_sbox_layer.sv
// Bench for khazad_sbox_layer: vector table, scoreboard on the LANES=2
// instance, backpressure, mid-block reset and a LANES sweep.
module tb_khazad_sbox_layer;
  localparam int BYTES = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_in_valid;
  logic [63:0] tb_in_data;
  logic        tb_out_ready;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  khazad_sbox_layer_if #(.BYTES(BYTES)) if_l1 ();
  khazad_sbox_layer_if #(.BYTES(BYTES)) if_l2 ();
  khazad_sbox_layer_if #(.BYTES(BYTES)) if_l4 ();
  khazad_sbox_layer_if #(.BYTES(BYTES)) if_l8 ();

  assign if_l1.in_valid = tb_in_valid;  assign if_l1.in_data = tb_in_data;  assign if_l1.out_ready = tb_out_ready;
  assign if_l2.in_valid = tb_in_valid;  assign if_l2.in_data = tb_in_data;  assign if_l2.out_ready = tb_out_ready;
  assign if_l4.in_valid = tb_in_valid;  assign if_l4.in_data = tb_in_data;  assign if_l4.out_ready = tb_out_ready;
  assign if_l8.in_valid = tb_in_valid;  assign if_l8.in_data = tb_in_data;  assign if_l8.out_ready = tb_out_ready;

  khazad_sbox_layer #(.BYTES(BYTES), .LANES(1)) u_dut_l1 (.clk(clk), .rst(rst), .bus(if_l1.slave));
  khazad_sbox_layer #(.BYTES(BYTES), .LANES(2)) u_dut_l2 (.clk(clk), .rst(rst), .bus(if_l2.slave));
  khazad_sbox_layer #(.BYTES(BYTES), .LANES(4)) u_dut_l4 (.clk(clk), .rst(rst), .bus(if_l4.slave));
  khazad_sbox_layer #(.BYTES(BYTES), .LANES(8)) u_dut_l8 (.clk(clk), .rst(rst), .bus(if_l8.slave));

  logic [3:0]  sw_valid;
  logic [3:0]  sw_ready;
  logic [63:0] sw_data [4];
  assign sw_valid   = {if_l8.out_valid, if_l4.out_valid, if_l2.out_valid, if_l1.out_valid};
  assign sw_ready   = {if_l8.in_ready, if_l4.in_ready, if_l2.in_ready, if_l1.in_ready};
  assign sw_data[0] = if_l1.out_data;
  assign sw_data[1] = if_l2.out_data;
  assign sw_data[2] = if_l4.out_data;
  assign sw_data[3] = if_l8.out_data;

  // Reference KHAZAD S-box table.
  byte unsigned sb [256] = '{
    'hba,'h54,'h2f,'h74,'h53,'hd3,'hd2,'h4d,'h50,'hac,'h8d,'hbf,'h70,'h52,'h9a,'h4c,
    'hea,'hd5,'h97,'hd1,'h33,'h51,'h5b,'ha6,'hde,'h48,'ha8,'h99,'hdb,'h32,'hb7,'hfc,
    'he3,'h9e,'h91,'h9b,'he2,'hbb,'h41,'h6e,'ha5,'hcb,'h6b,'h95,'ha1,'hf3,'hb1,'h02,
    'hcc,'hc4,'h1d,'h14,'hc3,'h63,'hda,'h5d,'h5f,'hdc,'h7d,'hcd,'h7f,'h5a,'h6c,'h5c,
    'hf7,'h26,'hff,'hed,'he8,'h9d,'h6f,'h8e,'h19,'ha0,'hf0,'h89,'h0f,'h07,'haf,'hfb,
    'h08,'h15,'h0d,'h04,'h01,'h64,'hdf,'h76,'h79,'hdd,'h3d,'h16,'h3f,'h37,'h6d,'h38,
    'hb9,'h73,'he9,'h35,'h55,'h71,'h7b,'h8c,'h72,'h88,'hf6,'h2a,'h3e,'h5e,'h27,'h46,
    'h0c,'h65,'h68,'h61,'h03,'hc1,'h57,'hd6,'hd9,'h58,'hd8,'h66,'hd7,'h3a,'hc8,'h3c,
    'hfa,'h96,'ha7,'h98,'hec,'hb8,'hc7,'hae,'h69,'h4b,'hab,'ha9,'h67,'h0a,'h47,'hf2,
    'hb5,'h22,'he5,'hee,'hbe,'h2b,'h81,'h12,'h83,'h1b,'h0e,'h23,'hf5,'h45,'h21,'hce,
    'h49,'h2c,'hf9,'he6,'hb6,'h28,'h17,'h82,'h1a,'h8b,'hfe,'h8a,'h09,'hc9,'h87,'h4e,
    'he1,'h2e,'he4,'he0,'heb,'h90,'ha4,'h1e,'h85,'h60,'h00,'h25,'hf4,'hf1,'h94,'h0b,
    'he7,'h75,'hef,'h34,'h31,'hd4,'hd0,'h86,'h7e,'had,'hfd,'h29,'h30,'h3b,'h9f,'hf8,
    'hc6,'h13,'h06,'h05,'hc5,'h11,'h77,'h7c,'h7a,'h78,'h36,'h1c,'h39,'h59,'h18,'h56,
    'hb3,'hb0,'h24,'h20,'hb2,'h92,'ha3,'hc0,'h44,'h62,'h10,'hb4,'h84,'h43,'h93,'hc2,
    'h4a,'hbd,'h8f,'h2d,'hbc,'h9c,'h6a,'h40,'hcf,'ha2,'h80,'h4f,'h1f,'hca,'haa,'h42
  };

  function automatic logic [63:0] model(input logic [63:0] x);
    logic [63:0] y;
    for (int b = 0; b < 8; b++) y[8*b +: 8] = sb[x[8*b +: 8]];
    return y;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard on the LANES=2 instance: push on accept, pop on handoff.
  logic [63:0] exp_q [$];
  logic [63:0] mon_exp;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (if_l2.out_valid && tb_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_output: got %h expected none", if_l2.out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("sb_out", if_l2.out_data, mon_exp);
        end
      end
      if (tb_in_valid && if_l2.in_ready) exp_q.push_back(model(tb_in_data));
    end
  end

  // Called at posedge+1; returns after the handoff edge (out_ready assumed high).
  task automatic send_block(input logic [63:0] din, output int lat,
                            output logic [63:0] dout, output logic busy_ok);
    int w;
    w = 0;
    lat = -1;
    dout = '0;
    busy_ok = 1'b1;
    while (!if_l2.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    tb_in_valid = 1'b1;
    tb_in_data  = din;
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (!if_l2.busy) busy_ok = 1'b0;
      if (if_l2.out_valid) begin
        lat  = c;
        dout = if_l2.out_data;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [63:0] din;
    logic [63:0] dout;
  } vec_t;

  vec_t        vecs [5];
  int          lat;
  logic [63:0] dout;
  logic        bok;
  logic [63:0] orig, cur, bp_din;
  int          slat [4];
  logic [63:0] sdat [4];
  logic [3:0]  seen;
  int          lat_exp [4] = '{8, 4, 2, 1};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{64'h0000000000000000, 64'hBABABABABABABABA};
    vecs[1] = '{64'h0706050403020100, 64'h4DD2D353742F54BA};
    vecs[2] = '{64'hFFFEFDFCFBFAF9F8, 64'h42AACA1F4F80A2CF};
    vecs[3] = '{64'h0123456789ABCDEF, 64'h549B9D8C4B8A3BC2};
    vecs[4] = '{64'hBABABABABABABABA, 64'h0000000000000000};

    rst = 1'b1;
    tb_in_valid = 1'b0;
    tb_in_data = '0;
    tb_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", if_l2.in_ready, 0);
    chk("reset_out_valid", if_l2.out_valid, 0);
    chk("reset_busy", if_l2.busy, 0);
    chk("reset_out_data", if_l2.out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", if_l2.in_ready, 1);
    @(posedge clk); #1;

    // Vector table on LANES=2
    for (int i = 0; i < 5; i++) begin
      send_block(vecs[i].din, lat, dout, bok);
      chk($sformatf("vec%0d_data", i), dout, vecs[i].dout);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_busy", i), bok, 1);
      chk($sformatf("vec%0d_ready_after", i), if_l2.in_ready, 1);
    end

    // Involution: pairs of blocks, the second fed with the first's result
    for (int n = 0; n < 1000; n++) begin
      if (n % 2 == 0) begin
        cur  = {$urandom, $urandom};
        orig = cur;
      end
      send_block(cur, lat, dout, bok);
      if (lat < 0) begin
        chk("rand_timeout", lat, 4);
        break;
      end
      if (n % 2 == 1) chk("involution", dout, orig);
      cur = dout;
    end

    // Backpressure: hold out_ready low for 5 cycles after out_valid
    tb_out_ready = 1'b0;
    bp_din = 64'h1122334455667788;
    tb_in_valid = 1'b1;
    tb_in_data = bp_din;
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (if_l2.out_valid) begin
        lat = c;
        break;
      end
    end
    chk("bp_latency", lat, 4);
    @(posedge clk); #1;
    tb_in_valid = 1'b1;
    tb_in_data = ~bp_din;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("bp_valid_held", if_l2.out_valid, 1);
      chk("bp_data_held", if_l2.out_data, model(bp_din));
      chk("bp_in_ready_low", if_l2.in_ready, 0);
      @(posedge clk); #1;
    end
    tb_in_valid = 1'b0;
    tb_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_at_release", if_l2.out_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_valid_after_handoff", if_l2.out_valid, 0);
    chk("bp_in_ready_after_handoff", if_l2.in_ready, 1);
    chk("bp_data_kept", if_l2.out_data, model(bp_din));
    @(posedge clk); #1;

    // Reset in the middle of a block
    tb_in_valid = 1'b1;
    tb_in_data = 64'hDEADBEEFCAFEF00D;
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_low", if_l2.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", if_l2.out_valid, 0);
    chk("rst_busy", if_l2.busy, 0);
    chk("rst_out_data", if_l2.out_data, 0);
    chk("rst_in_ready_high", if_l2.in_ready, 1);
    @(posedge clk); #1;
    send_block(64'h0, lat, dout, bok);
    chk("rst_next_data", dout, 64'hBABABABABABABABA);
    chk("rst_next_latency", lat, 4);

    // LANES sweep: all instances take the same block on the same edge
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int v = 0; v < 4; v++) begin
      for (int w = 0; w < 50 && sw_ready != 4'hF; w++) begin
        @(posedge clk); #1;
      end
      chk("sweep_all_ready", sw_ready, 4'hF);
      tb_in_valid = 1'b1;
      tb_in_data = vecs[v].din;
      @(posedge clk); #1;
      tb_in_valid = 1'b0;
      seen = '0;
      for (int k = 0; k < 4; k++) begin
        slat[k] = -1;
        sdat[k] = '0;
      end
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          if (!seen[k] && sw_valid[k]) begin
            seen[k] = 1'b1;
            slat[k] = c;
            sdat[k] = sw_data[k];
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("sweep_v%0d_lat_beats%0d", v, lat_exp[k]), slat[k], lat_exp[k]);
        chk($sformatf("sweep_v%0d_data_beats%0d", v, lat_exp[k]), sdat[k], vecs[v].dout);
      end
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
